fft_inplace_ctrl: RTL and testbench

- Parametrised controller for the radix-2, in-place, two-bank FFT datapath. It generalises the fixed 64-point controller to 2^LOG2N points with a configurable butterfly latency.
- Owns its own sample/stage counters instead of taking an external count.
- Provides valid/ready handshakes on load and unload, and stalls the output stage on back-pressure.
- Drives bank enables, addresses and swap selects for the two N/2-deep sample banks and the butterfly's swap muxes.

---
 rtl/fft_inplace_ctrl_pkg.sv | 35 +++
 rtl/fft_inplace_ctrl_addr_delay.sv | 52 +++++
 rtl/fft_inplace_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_fft_inplace_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_inplace_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//   Shared definitions for the in-place radix-2 FFT controller:
//   - state_t : controller FSM states (LOAD, STAGE, GAP, UNLOAD)
//   - N, HALF : point count and bank depth of the default 64-point build
//   - par()   : XOR-reduction of the low 'bits' bits of a value; this is the
//               bank-select function for the two-bank sample memory
// ---------------------------------------------------------------------------
package fft_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STAGE  = 2'd1,
    GAP    = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  localparam int LOG2N_DEF = 6;
  localparam int N         = 1 << LOG2N_DEF;
  localparam int HALF      = N / 2;

  // Parity of the low 'bits' bits of x. The loop is fixed at 32 iterations so
  // it unrolls to a plain XOR tree whatever the caller's width is.
  function automatic logic par(input logic [31:0] x, input int bits);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) begin
        p = p ^ x[i];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/fft_inplace_ctrl_addr_delay.sv
// ---------------------------------------------------------------------------
// fft_addr_delay
//   DEPTH-stage shift register carrying {we, addr} for both sample banks.
//   It turns the read enable/address issued during a butterfly stage into
//   the matching write enable/address DEPTH cycles later, so results land
//   back at the addresses they were read from.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset (clears pipe)
//   we0_in,  we1_in      write-enable candidates for bank 0 / bank 1
//   addr0_in, addr1_in   addresses for bank 0 / bank 1
//   we0_out, we1_out     delayed write enables
//   addr0_out, addr1_out delayed addresses
// ---------------------------------------------------------------------------
module fft_addr_delay
  import fft_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we0_in,
  input  logic          we1_in,
  input  logic [AW-1:0] addr0_in,
  input  logic [AW-1:0] addr1_in,
  output logic          we0_out,
  output logic          we1_out,
  output logic [AW-1:0] addr0_out,
  output logic [AW-1:0] addr1_out
);

  localparam int W = 2 * (AW + 1);

  logic [W-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= {we0_in, addr0_in, we1_in, addr1_in};
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign {we0_out, addr0_out, we1_out, addr1_out} = pipe[DEPTH-1];

endmodule

// File: rtl/fft_inplace_ctrl.sv
// ---------------------------------------------------------------------------
// fft_inplace_ctrl
//   Controller for a radix-2, in-place FFT built on two N/2-deep sample
//   banks. Sample k lives in bank par(k) at address k>>1, which guarantees
//   that both operands of every butterfly sit in different banks, so one
//   read and one write per bank per cycle is enough.
//
//   Flow: LOAD (N samples via valid/ready) -> STAGE/GAP repeated LOG2N-1
//   times -> UNLOAD (N/2 pairs, stalls on out_ready) -> LOAD.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   load handshake; a sample is written when both high
//   out_ready             downstream accepts the pair read this cycle
//   out_valid             pair read last cycle is on the bank read ports
//   out_last              qualifies the final output pair
//   busy                  high outside LOAD
//   done                  one-cycle pulse after the last output handshake
//   stage                 current stage index (LOG2N-1 during UNLOAD)
//   we_b*, waddr_b*       bank write enables / addresses
//   re_b*, raddr_b*       bank read enables / addresses
//   swap0_en, swap1_en    butterfly swap selects, aligned with read data
// ---------------------------------------------------------------------------
module fft_inplace_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2N  = 6,
  parameter int AW     = LOG2N - 1,
  parameter int BF_LAT = 1,
  parameter int SW     = $clog2(LOG2N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] stage,
  output logic          we_b0,
  output logic          we_b1,
  output logic          re_b0,
  output logic          re_b1,
  output logic [AW-1:0] waddr_b0,
  output logic [AW-1:0] waddr_b1,
  output logic [AW-1:0] raddr_b0,
  output logic [AW-1:0] raddr_b1,
  output logic          swap0_en,
  output logic          swap1_en
);

  localparam int GW = 3;

  state_t          state;
  logic [LOG2N-1:0] k;
  logic [AW-1:0]   j;
  logic [SW-1:0]   s;
  logic [GW-1:0]   g;

  logic swap0_q;
  logic swap1_q;
  logic out_valid_q;
  logic out_last_q;
  logic done_q;

  logic [AW-1:0] bmask;
  logic [AW-1:0] j_partner;
  logic [AW-1:0] k_addr;
  logic          j_bit;
  logic          par_k;
  logic          par_j2;
  logic          stage_rd;

  logic          dly_we0;
  logic          dly_we1;
  logic [AW-1:0] dly_addr0;
  logic [AW-1:0] dly_addr1;
  logic [AW-1:0] dly_in0;
  logic [AW-1:0] dly_in1;

  // Butterfly partner distance for stage s is 1 << (LOG2N-2-s). Outside
  // STAGE the mask is unused, so an out-of-range shift there is harmless.
  assign bmask     = {{(AW-1){1'b0}}, 1'b1} << (SW'(LOG2N-2) - s);
  assign j_partner = j ^ bmask;
  assign j_bit     = |(j & bmask);
  assign k_addr    = k[LOG2N-1:1];
  assign par_k     = par(32'(k), LOG2N);
  assign par_j2    = par(32'({j, 1'b0}), LOG2N);
  assign stage_rd  = (state == STAGE);

  // Only butterfly reads feed the write pipe; UNLOAD reads never write back,
  // and zero addresses keep the write ports quiet once the pipe drains.
  assign dly_in0 = stage_rd ? j : '0;
  assign dly_in1 = stage_rd ? j_partner : '0;

  fft_addr_delay #(
    .AW    (AW),
    .DEPTH (BF_LAT)
  ) u_addr_delay (
    .clk       (clk),
    .rst       (rst),
    .we0_in    (stage_rd),
    .we1_in    (stage_rd),
    .addr0_in  (dly_in0),
    .addr1_in  (dly_in1),
    .we0_out   (dly_we0),
    .we1_out   (dly_we1),
    .addr0_out (dly_addr0),
    .addr1_out (dly_addr1)
  );

  // Main FSM with its counters and the registered, read-aligned outputs.
  // k, j wrap to zero on their own at the end of each phase because they are
  // exactly LOG2N and LOG2N-1 bits wide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      k           <= '0;
      j           <= '0;
      s           <= '0;
      g           <= '0;
      swap0_q     <= 1'b0;
      swap1_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      swap0_q     <= 1'b0;
      swap1_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      case (state)
        LOAD: begin
          if (in_valid) begin
            k <= k + 1'b1;
            if (&k) begin
              state <= STAGE;
              j     <= '0;
              s     <= '0;
            end
          end
        end
        STAGE: begin
          swap0_q <= j_bit;
          swap1_q <= j_bit;
          j       <= j + 1'b1;
          if (&j) begin
            state <= GAP;
            g     <= '0;
          end
        end
        GAP: begin
          // Hold off reads until the last BF_LAT writes have landed.
          if (g == GW'(BF_LAT - 1)) begin
            g     <= '0;
            s     <= s + 1'b1;
            state <= (s == SW'(LOG2N - 2)) ? UNLOAD : STAGE;
          end else begin
            g <= g + 1'b1;
          end
        end
        UNLOAD: begin
          swap0_q <= par_j2;
          if (out_ready) begin
            out_valid_q <= 1'b1;
            out_last_q  <= &j;
            j           <= j + 1'b1;
            if (&j) begin
              done_q <= 1'b1;
              state  <= LOAD;
              s      <= '0;
            end
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  // Output decode. Everything is forced low while rst is asserted; load
  // writes follow in_valid directly so a sample is stored in its handshake
  // cycle, while compute writes come from the delay pipe.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    stage     = '0;
    re_b0     = 1'b0;
    re_b1     = 1'b0;
    raddr_b0  = '0;
    raddr_b1  = '0;
    we_b0     = 1'b0;
    we_b1     = 1'b0;
    waddr_b0  = '0;
    waddr_b1  = '0;
    swap0_en  = 1'b0;
    swap1_en  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    if (!rst) begin
      busy      = (state != LOAD);
      stage     = s;
      swap0_en  = swap0_q;
      swap1_en  = swap1_q;
      out_valid = out_valid_q;
      out_last  = out_last_q;
      done      = done_q;
      case (state)
        LOAD: begin
          in_ready = 1'b1;
          we_b0    = in_valid & ~par_k;
          we_b1    = in_valid & par_k;
          waddr_b0 = k_addr;
          waddr_b1 = k_addr;
        end
        STAGE: begin
          re_b0    = 1'b1;
          re_b1    = 1'b1;
          raddr_b0 = j;
          raddr_b1 = j_partner;
        end
        UNLOAD: begin
          re_b0    = out_ready;
          re_b1    = out_ready;
          raddr_b0 = j;
          raddr_b1 = j;
        end
        default: begin
        end
      endcase
      if (state != LOAD) begin
        we_b0    = dly_we0;
        we_b1    = dly_we1;
        waddr_b0 = dly_addr0;
        waddr_b1 = dly_addr1;
      end
    end
  end

endmodule

// File: tb/tb_fft_inplace_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_inplace_ctrl
//   Directed bench for two controller builds sharing one clock:
//   dut_a : LOG2N=6, BF_LAT=1 (64 points)
//   dut_b : LOG2N=4, BF_LAT=3 (16 points)
//   Inputs change just after the falling edge and outputs are sampled 1 time
//   unit later, well clear of the rising edge.
// ---------------------------------------------------------------------------
module tb_fft_inplace_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic       a_in_valid, a_out_ready;
  logic       a_in_ready, a_out_valid, a_out_last, a_busy, a_done;
  logic [2:0] a_stage;
  logic       a_we_b0, a_we_b1, a_re_b0, a_re_b1;
  logic [4:0] a_waddr_b0, a_waddr_b1, a_raddr_b0, a_raddr_b1;
  logic       a_swap0_en, a_swap1_en;

  logic       b_in_valid, b_out_ready;
  logic       b_in_ready, b_out_valid, b_out_last, b_busy, b_done;
  logic [1:0] b_stage;
  logic       b_we_b0, b_we_b1, b_re_b0, b_re_b1;
  logic [2:0] b_waddr_b0, b_waddr_b1, b_raddr_b0, b_raddr_b1;
  logic       b_swap0_en, b_swap1_en;

  int errors = 0;
  int checks = 0;
  int a_done_cnt = 0;
  int a_ov_cnt = 0;

  fft_inplace_ctrl #(.LOG2N(6), .BF_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_ready(a_out_ready), .out_valid(a_out_valid), .out_last(a_out_last),
    .busy(a_busy), .done(a_done), .stage(a_stage),
    .we_b0(a_we_b0), .we_b1(a_we_b1), .re_b0(a_re_b0), .re_b1(a_re_b1),
    .waddr_b0(a_waddr_b0), .waddr_b1(a_waddr_b1),
    .raddr_b0(a_raddr_b0), .raddr_b1(a_raddr_b1),
    .swap0_en(a_swap0_en), .swap1_en(a_swap1_en)
  );

  fft_inplace_ctrl #(.LOG2N(4), .BF_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_ready(b_out_ready), .out_valid(b_out_valid), .out_last(b_out_last),
    .busy(b_busy), .done(b_done), .stage(b_stage),
    .we_b0(b_we_b0), .we_b1(b_we_b1), .re_b0(b_re_b0), .re_b1(b_re_b1),
    .waddr_b0(b_waddr_b0), .waddr_b1(b_waddr_b1),
    .raddr_b0(b_raddr_b0), .raddr_b1(b_raddr_b1),
    .swap0_en(b_swap0_en), .swap1_en(b_swap1_en)
  );

  // One clock cycle: drive inputs after the falling edge, let them settle,
  // and keep a running tally of dut_a done pulses and output beats.
  task automatic applyStimulus(input logic aiv, input logic ardy,
                               input logic biv, input logic brdy);
    @(negedge clk);
    a_in_valid  = aiv;
    a_out_ready = ardy;
    b_in_valid  = biv;
    b_out_ready = brdy;
    #1;
    if (a_done) a_done_cnt++;
    if (a_out_valid) a_ov_cnt++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int b0_cnt, b1_cnt, addr_bad, acc, done_n, gap_cnt, gap_we;
    logic [5:0] acc_v;
    logic exp_bank;

    rst = 1'b1;
    a_in_valid = 0; a_out_ready = 0; b_in_valid = 0; b_out_ready = 0;

    // ---------------- reset ----------------
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 1, 1, 1);
    checkOutput("rst_in_ready",  32'(a_in_ready), 0);
    checkOutput("rst_we_gated",  32'(a_we_b0), 0);
    checkOutput("rst_b_ready",   32'(b_in_ready), 0);
    applyStimulus(0, 0, 0, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(a_in_ready), 1);
    checkOutput("post_rst_busy",  32'(a_busy), 0);
    checkOutput("post_rst_stage", 32'(a_stage), 0);

    // ---------------- dut_a dense load ----------------
    for (int kk = 0; kk < 64; kk++) begin
      applyStimulus(1, 0, 0, 0);
      if (kk == 3) begin
        checkOutput("k3_we_b0",    32'(a_we_b0), 1);
        checkOutput("k3_we_b1",    32'(a_we_b1), 0);
        checkOutput("k3_waddr_b0", 32'(a_waddr_b0), 1);
      end
      if (kk == 7) begin
        checkOutput("k7_we_b1",    32'(a_we_b1), 1);
        checkOutput("k7_we_b0",    32'(a_we_b0), 0);
        checkOutput("k7_waddr_b1", 32'(a_waddr_b1), 3);
      end
    end

    // ---------------- dut_a stage 0 ----------------
    applyStimulus(0, 0, 0, 0);
    checkOutput("s0j0_in_ready", 32'(a_in_ready), 0);
    checkOutput("s0j0_busy",     32'(a_busy), 1);
    checkOutput("s0j0_re",       32'(a_re_b0), 1);
    checkOutput("s0j0_raddr_b1", 32'(a_raddr_b1), 16);
    for (int i = 1; i <= 5; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("s0j5_raddr_b0", 32'(a_raddr_b0), 5);
    checkOutput("s0j5_raddr_b1", 32'(a_raddr_b1), 21);
    applyStimulus(0, 0, 0, 0);
    checkOutput("s0j6_swap0",    32'(a_swap0_en), 0);
    checkOutput("s0j6_we_b0",    32'(a_we_b0), 1);
    checkOutput("s0j6_waddr_b0", 32'(a_waddr_b0), 5);
    checkOutput("s0j6_waddr_b1", 32'(a_waddr_b1), 21);
    for (int i = 7; i <= 20; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("s0j20_raddr_b0", 32'(a_raddr_b0), 20);
    checkOutput("s0j20_raddr_b1", 32'(a_raddr_b1), 4);
    applyStimulus(0, 0, 0, 0);
    checkOutput("s0j21_swap0",    32'(a_swap0_en), 1);
    checkOutput("s0j21_swap1",    32'(a_swap1_en), 1);
    checkOutput("s0j21_we_b0",    32'(a_we_b0), 1);
    checkOutput("s0j21_we_b1",    32'(a_we_b1), 1);
    checkOutput("s0j21_waddr_b0", 32'(a_waddr_b0), 20);
    checkOutput("s0j21_waddr_b1", 32'(a_waddr_b1), 4);
    for (int i = 22; i <= 31; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("s0j31_raddr_b1", 32'(a_raddr_b1), 15);
    applyStimulus(0, 0, 0, 0);
    checkOutput("gap0_re",       32'(a_re_b0), 0);
    checkOutput("gap0_we",       32'(a_we_b0), 1);
    checkOutput("gap0_waddr_b0", 32'(a_waddr_b0), 31);
    checkOutput("gap0_waddr_b1", 32'(a_waddr_b1), 15);
    checkOutput("gap0_stage",    32'(a_stage), 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("s1j0_stage",    32'(a_stage), 1);
    checkOutput("s1j0_raddr_b1", 32'(a_raddr_b1), 8);
    checkOutput("s1j0_we",       32'(a_we_b0), 0);
    for (int i = 0; i < 33; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("s2j0_stage",    32'(a_stage), 2);
    checkOutput("s2j0_raddr_b1", 32'(a_raddr_b1), 4);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("s2j3_raddr_b1", 32'(a_raddr_b1), 7);

    // ---------------- reset during stage 2 ----------------
    applyStimulus(0, 0, 0, 0);
    rst = 1'b1;
    #1;
    checkOutput("abort_rst_re",    32'(a_re_b0), 0);
    checkOutput("abort_rst_stage", 32'(a_stage), 0);
    a_done_cnt = 0;
    applyStimulus(0, 0, 0, 0);
    rst = 1'b0;
    #1;
    checkOutput("abort_in_ready", 32'(a_in_ready), 1);
    checkOutput("abort_busy",     32'(a_busy), 0);
    checkOutput("abort_re",       32'(a_re_b0), 0);
    checkOutput("abort_we",       32'(a_we_b0 | a_we_b1), 0);
    checkOutput("abort_stage",    32'(a_stage), 0);
    checkOutput("abort_done",     32'(a_done), 0);

    // ---------------- gapped reload ----------------
    b0_cnt = 0; b1_cnt = 0; addr_bad = 0; acc = 0;
    for (int i = 0; i < 128; i++) begin
      applyStimulus((i % 2) == 0, 0, 0, 0);
      if (a_in_valid && a_in_ready) begin
        acc_v = 6'(acc);
        exp_bank = ^acc_v;
        if ((exp_bank == 1'b0 && a_we_b0 !== 1'b1) ||
            (exp_bank == 1'b1 && a_we_b1 !== 1'b1)) addr_bad++;
        acc++;
      end
      if (a_we_b0 && a_we_b1) addr_bad++;
      if (a_we_b0) begin
        if (a_waddr_b0 != 5'(b0_cnt)) addr_bad++;
        b0_cnt++;
      end
      if (a_we_b1) begin
        if (a_waddr_b1 != 5'(b1_cnt)) addr_bad++;
        b1_cnt++;
      end
    end
    checkOutput("gapload_writes",   32'(b0_cnt + b1_cnt), 64);
    checkOutput("gapload_b0_count", 32'(b0_cnt), 32);
    checkOutput("gapload_addr_bad", 32'(addr_bad), 0);
    checkOutput("gapload_ready_lo", 32'(a_in_ready), 0);
    checkOutput("abort_no_done",    32'(a_done_cnt), 0);

    // ---------------- run to UNLOAD, then toggle out_ready ----------------
    for (int i = 0; i < 164; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("last_gap_stage", 32'(a_stage), 4);
    a_done_cnt = 0;
    a_ov_cnt = 0;
    for (int u = 0; u <= 64; u++) begin
      applyStimulus(0, (u % 2) == 0, 0, 0);
      if (u == 0) begin
        checkOutput("u0_stage", 32'(a_stage), 5);
        checkOutput("u0_re",    32'(a_re_b0), 1);
        checkOutput("u0_raddr", 32'(a_raddr_b0), 0);
        checkOutput("u0_we",    32'(a_we_b0 | a_we_b1), 0);
      end
      if (u == 1) begin
        checkOutput("u1_re",        32'(a_re_b0), 0);
        checkOutput("u1_raddr",     32'(a_raddr_b0), 1);
        checkOutput("u1_out_valid", 32'(a_out_valid), 1);
        checkOutput("u1_swap0",     32'(a_swap0_en), 0);
      end
      if (u == 2) begin
        checkOutput("u2_out_valid", 32'(a_out_valid), 0);
        checkOutput("u2_re_b1",     32'(a_re_b1), 1);
        checkOutput("u2_raddr_b1",  32'(a_raddr_b1), 1);
      end
      if (u == 3) begin
        checkOutput("u3_swap0",    32'(a_swap0_en), 1);
        checkOutput("u3_swap1",    32'(a_swap1_en), 0);
        checkOutput("u3_out_last", 32'(a_out_last), 0);
      end
      if (u == 7) checkOutput("u7_swap0", 32'(a_swap0_en), 0);
      if (u == 62) begin
        checkOutput("u62_raddr", 32'(a_raddr_b0), 31);
        checkOutput("u62_done",  32'(a_done), 0);
      end
      if (u == 63) begin
        checkOutput("u63_out_last",  32'(a_out_last), 1);
        checkOutput("u63_out_valid", 32'(a_out_valid), 1);
        checkOutput("u63_done",      32'(a_done), 1);
        checkOutput("u63_in_ready",  32'(a_in_ready), 1);
        checkOutput("u63_busy",      32'(a_busy), 0);
      end
      if (u == 64) checkOutput("u64_done", 32'(a_done), 0);
    end
    checkOutput("unload_beats", 32'(a_ov_cnt), 32);
    checkOutput("unload_dones", 32'(a_done_cnt), 1);

    // ---------------- dut_b: 16 points, BF_LAT=3 ----------------
    for (int kk = 0; kk < 16; kk++) applyStimulus(0, 0, 1, 1);
    done_n = 0; gap_cnt = 0; gap_we = 0;
    for (int n = 1; n <= 200; n++) begin
      applyStimulus(0, 0, 0, 1);
      if (n == 1)  checkOutput("b_n1_stage", 32'(b_stage), 0);
      if (n == 3)  checkOutput("b_n3_we", 32'(b_we_b0), 0);
      if (n == 4) begin
        checkOutput("b_n4_we",       32'(b_we_b0), 1);
        checkOutput("b_n4_waddr_b1", 32'(b_waddr_b1), 4);
      end
      if (n == 9) begin
        checkOutput("b_gap_re",       32'(b_re_b0), 0);
        checkOutput("b_gap_stage",    32'(b_stage), 0);
        checkOutput("b_gap_waddr_b0", 32'(b_waddr_b0), 5);
        checkOutput("b_gap_waddr_b1", 32'(b_waddr_b1), 1);
      end
      if (n == 12) checkOutput("b_n12_stage", 32'(b_stage), 1);
      if (n == 23) checkOutput("b_n23_stage", 32'(b_stage), 2);
      if (n == 34) checkOutput("b_n34_stage", 32'(b_stage), 3);
      if (b_busy && b_stage < 2'd3 && !b_re_b0) begin
        gap_cnt++;
        if (b_we_b0 && b_we_b1) gap_we++;
      end
      if (b_done) begin
        done_n = n;
        checkOutput("b_done_last", 32'(b_out_last), 1);
        break;
      end
    end
    checkOutput("b_latency",  32'(done_n), 42);
    checkOutput("b_gap_reoff", 32'(gap_cnt), 9);
    checkOutput("b_gap_writes", 32'(gap_we), 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
